// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and selector encodings for the memory stage.
//   state_t         - two-word operation sequencer (IDLE / SECOND)
//   ADDR_*          - memory_address_select encodings
//   SRC_*           - memory_write_src_select encodings (1x = 32-bit PC sources)
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_RESULT = 2'b00;
    localparam logic [1:0] ADDR_RDEST  = 2'b01;
    localparam logic [1:0] ADDR_STACK  = 2'b10;

    localparam logic [1:0] SRC_RSRC  = 2'b00;
    localparam logic [1:0] SRC_RDEST = 2'b01;
    localparam logic [1:0] SRC_PC    = 2'b10;
    localparam logic [1:0] SRC_PC1   = 2'b11;

endpackage

// File: rtl/memory_stage_data_memory.sv
// data_memory: 2**ADDR_W x 16-bit data RAM, one shared address port.
//   i_clk   - clock
//   i_we    - write enable (synchronous write)
//   i_addr  - word address for both read and write
//   i_wdata - write data
//   o_rdata - asynchronous read data; a same-cycle write is not visible
//             until the next cycle, so read-during-write returns old data.
// Contents are not reset.
module data_memory #(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage: fourth pipeline stage. Loads/stores, stack push/pop, and
// two-word PC push (CALL/INT) / PC pop (RET/RTI). Owns the stack pointer
// and the MEM/WB buffer.
//   inputs : EX/MEM buffer fields (result, Rdest/Rsrc data, PC, PC+1,
//            LDM/input-port pass-throughs, memory op controls, WB controls)
//   outputs: MEM/WB buffer fields, restored PC + one-cycle valid pulse,
//            combinational stall to earlier stages, stack pointer (debug)
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int SP_RESET = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       result_in,
    input  logic [15:0]       read_data1_in,
    input  logic [15:0]       read_data2_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       pc_plus_one_in,
    input  logic [15:0]       LDM_value_in,
    input  logic [15:0]       input_port_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic              pc_choose_memory,
    input  logic              reg_write,
    input  logic              outport_enable,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        reg_write_address,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       result_out,
    output logic [15:0]       LDM_value_out,
    output logic [15:0]       input_port_out,
    output logic              reg_write_out,
    output logic              outport_enable_out,
    output logic [1:0]        wb_sel_out,
    output logic [2:0]        reg_write_address_out,
    output logic [31:0]       new_pc_out,
    output logic              pc_from_mem_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sp_out
);

    localparam logic [ADDR_W-1:0] SP_RST = SP_RESET[ADDR_W-1:0];

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_sp;
    logic [15:0]       r_hold;

    logic              w_push, w_pop, w_push32, w_pc_pop, w_long;
    logic [ADDR_W-1:0] w_sp_inc, w_sp_dec, w_addr;
    logic [31:0]       w_src32;
    logic [15:0]       w_wdata, w_rdata;
    logic              w_we;
    logic              w_unused;

    // Push wins over pop when both are asserted.
    assign w_push   = mem_push;
    assign w_pop    = mem_pop & ~mem_push;
    assign w_push32 = w_push & memory_write_src_select[1];
    assign w_pc_pop = w_pop & pc_choose_memory;
    assign w_long   = w_push32 | w_pc_pop;

    assign w_sp_inc = r_sp + ADDR_W'(1);
    assign w_sp_dec = r_sp - ADDR_W'(1);
    assign w_src32  = memory_write_src_select[0] ? pc_plus_one_in : pc_in;

    // Stack ops ignore the address selector: push uses SP, pop uses SP+1.
    always_comb begin
        w_addr = result_in[ADDR_W-1:0];
        if (w_push)      w_addr = r_sp;
        else if (w_pop)  w_addr = w_sp_inc;
        else begin
            case (memory_address_select)
                ADDR_RDEST: w_addr = read_data1_in[ADDR_W-1:0];
                ADDR_STACK: w_addr = r_sp;
                default:    w_addr = result_in[ADDR_W-1:0];
            endcase
        end
    end

    // 32-bit push writes the high word first so it lands at the higher address.
    always_comb begin
        w_wdata = read_data2_in;
        if (w_push32) begin
            w_wdata = (r_state == IDLE) ? w_src32[31:16] : w_src32[15:0];
        end else begin
            case (memory_write_src_select)
                SRC_RDEST: w_wdata = read_data1_in;
                SRC_PC:    w_wdata = pc_in[15:0];
                SRC_PC1:   w_wdata = pc_plus_one_in[15:0];
                default:   w_wdata = read_data2_in;
            endcase
        end
    end

    // Writes are blocked during reset so an abandoned 32-bit push keeps only its first word.
    assign w_we = ~reset & (w_push | mem_write);

    data_memory #(.ADDR_W(ADDR_W)) u_dmem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_long ? SECOND : IDLE;
            SECOND:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs -- hold earlier stages only during the first word.
    always_comb begin
        stall = 1'b0;
        if (!reset && r_state == IDLE && w_long) stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp              <= SP_RST;
            r_hold            <= 16'h0;
            new_pc_out        <= 32'h0;
            pc_from_mem_valid <= 1'b0;
        end else begin
            if (w_push)     r_sp <= w_sp_dec;
            else if (w_pop) r_sp <= w_sp_inc;

            if (w_pc_pop && r_state == IDLE) r_hold <= w_rdata;

            pc_from_mem_valid <= w_pc_pop && (r_state == SECOND);
            if (w_pc_pop && r_state == SECOND) new_pc_out <= {w_rdata, r_hold};
        end
    end

    // MEM/WB buffer; a stall cycle inserts a bubble by dropping the write enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data_out          <= 16'h0;
            result_out            <= 16'h0;
            LDM_value_out         <= 16'h0;
            input_port_out        <= 16'h0;
            reg_write_out         <= 1'b0;
            outport_enable_out    <= 1'b0;
            wb_sel_out            <= 2'b00;
            reg_write_address_out <= 3'b000;
        end else if (stall) begin
            reg_write_out      <= 1'b0;
            outport_enable_out <= 1'b0;
        end else begin
            mem_data_out          <= w_rdata;
            result_out            <= result_in;
            LDM_value_out         <= LDM_value_in;
            input_port_out        <= input_port_in;
            reg_write_out         <= reg_write;
            outport_enable_out    <= outport_enable;
            wb_sel_out            <= wb_sel;
            reg_write_address_out <= reg_write_address;
        end
    end

    assign sp_out = r_sp;

    // Address bits above ADDR_W are intentionally dropped.
    assign w_unused = ^{result_in[15:ADDR_W], read_data1_in[15:ADDR_W]};

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result_in, read_data1_in, read_data2_in, LDM_value_in, input_port_in;
    logic [31:0] pc_in, pc_plus_one_in;
    logic        mem_read, mem_write, mem_push, mem_pop, pc_choose_memory;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic        reg_write, outport_enable;
    logic [2:0]  reg_write_address;
    logic [15:0] mem_data_out, result_out, LDM_value_out, input_port_out;
    logic        reg_write_out, outport_enable_out, pc_from_mem_valid, stall;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out;
    logic [31:0] new_pc_out;
    logic [11:0] sp_out;

    memory_stage #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset),
        .result_in(result_in), .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
        .pc_in(pc_in), .pc_plus_one_in(pc_plus_one_in),
        .LDM_value_in(LDM_value_in), .input_port_in(input_port_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .pc_choose_memory(pc_choose_memory),
        .reg_write(reg_write), .outport_enable(outport_enable),
        .wb_sel(wb_sel), .reg_write_address(reg_write_address),
        .mem_data_out(mem_data_out), .result_out(result_out),
        .LDM_value_out(LDM_value_out), .input_port_out(input_port_out),
        .reg_write_out(reg_write_out), .outport_enable_out(outport_enable_out),
        .wb_sel_out(wb_sel_out), .reg_write_address_out(reg_write_address_out),
        .new_pc_out(new_pc_out), .pc_from_mem_valid(pc_from_mem_valid),
        .stall(stall), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 0;

    // Reference model: word-addressed array plus stack pointer and
    // "first half of a two-word op done" flag.
    logic [15:0] m_mem [4096];
    bit          m_known [4096];
    logic [11:0] m_sp;
    bit          m_half;
    logic [15:0] m_hold;
    logic [15:0] e_md, e_res, e_ldm, e_inp;
    bit          e_md_known, e_rw, e_oe, e_valid, e_stall;
    logic [1:0]  e_wbsel;
    logic [2:0]  e_rwa;
    logic [31:0] e_newpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_comb();
        e_stall = !reset && !m_half &&
                  ((mem_push && memory_write_src_select[1]) ||
                   (!mem_push && mem_pop && pc_choose_memory));
    endtask

    task automatic model_seq();
        bit push, pop, long32, pcpop, stl;
        logic [11:0] a;
        logic [15:0] rd, wd;
        bit rk;
        logic [31:0] pc32;
        if (reset) begin
            m_sp = 12'hFFF; m_half = 0; m_hold = 0;
            e_md = 0; e_res = 0; e_ldm = 0; e_inp = 0; e_md_known = 1;
            e_rw = 0; e_oe = 0; e_wbsel = 0; e_rwa = 0; e_newpc = 0; e_valid = 0;
            return;
        end
        push   = mem_push;
        pop    = mem_pop && !mem_push;
        long32 = push && memory_write_src_select[1];
        pcpop  = pop && pc_choose_memory;
        stl    = !m_half && (long32 || pcpop);
        pc32   = memory_write_src_select[0] ? pc_plus_one_in : pc_in;
        if (push)                            a = m_sp;
        else if (pop)                        a = m_sp + 12'd1;
        else if (memory_address_select == 1) a = read_data1_in[11:0];
        else if (memory_address_select == 2) a = m_sp;
        else                                 a = result_in[11:0];
        rd = m_mem[a];
        rk = m_known[a];
        if (push || mem_write) begin
            if (long32)                              wd = m_half ? pc32[15:0] : pc32[31:16];
            else if (memory_write_src_select == 0)   wd = read_data2_in;
            else if (memory_write_src_select == 1)   wd = read_data1_in;
            else                                     wd = pc32[15:0];
            m_mem[a] = wd;
            m_known[a] = 1;
        end
        if (push)     m_sp = m_sp - 12'd1;
        else if (pop) m_sp = m_sp + 12'd1;
        e_valid = 0;
        if (pcpop) begin
            if (!m_half) m_hold = rd;
            else begin
                e_newpc = {rd, m_hold};
                e_valid = 1;
            end
        end
        if (stl) begin
            e_rw = 0; e_oe = 0;
        end else begin
            e_md = rd; e_md_known = rk;
            e_res = result_in; e_ldm = LDM_value_in; e_inp = input_port_in;
            e_rw = reg_write; e_oe = outport_enable; e_wbsel = wb_sel; e_rwa = reg_write_address;
        end
        m_half = stl;
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sp", 32'(sp_out), 32'(m_sp));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("reg_write_out", 32'(reg_write_out), 32'(e_rw));
            chk("outport_enable_out", 32'(outport_enable_out), 32'(e_oe));
            chk("wb_sel_out", 32'(wb_sel_out), 32'(e_wbsel));
            chk("reg_write_address_out", 32'(reg_write_address_out), 32'(e_rwa));
            chk("result_out", 32'(result_out), 32'(e_res));
            chk("LDM_value_out", 32'(LDM_value_out), 32'(e_ldm));
            chk("input_port_out", 32'(input_port_out), 32'(e_inp));
            chk("pc_from_mem_valid", 32'(pc_from_mem_valid), 32'(e_valid));
            chk("new_pc_out", new_pc_out, e_newpc);
            if (e_md_known) chk("mem_data_out", 32'(mem_data_out), 32'(e_md));
        end
    end

    task automatic nop();
        result_in = 0; read_data1_in = 0; read_data2_in = 0;
        pc_in = 0; pc_plus_one_in = 0; LDM_value_in = 0; input_port_in = 0;
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        memory_address_select = 0; memory_write_src_select = 0; pc_choose_memory = 0;
        reg_write = 0; outport_enable = 0; wb_sel = 0; reg_write_address = 0;
    endtask

    task automatic tick();
        #1;
        model_comb();
        @(posedge clk);
        #1;
        model_seq();
    endtask

    task automatic load(input logic [15:0] addr);
        nop(); mem_read = 1; result_in = addr; tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop(); reset = 1;
        tick();
        mon_en = 1;
        // a long op presented during reset must not stall
        mem_push = 1; memory_write_src_select = 2'b11; #1;
        chk("lit_stall_in_reset", 32'(stall), 32'h0);
        tick();
        chk("lit_reset_sp", 32'(sp_out), 32'hFFF);
        chk("lit_reset_rw", 32'(reg_write_out), 32'h0);
        chk("lit_reset_md", 32'(mem_data_out), 32'h0);
        chk("lit_reset_newpc", new_pc_out, 32'h0);
        reset = 0; nop(); tick();

        // word push, then pop with read
        nop(); mem_push = 1; memory_address_select = 2'b10; read_data2_in = 16'h1234; tick();
        chk("lit_push_sp", 32'(sp_out), 32'hFFE);
        nop(); mem_pop = 1; mem_read = 1; memory_address_select = 2'b10;
        reg_write = 1; wb_sel = 2'b01; reg_write_address = 3'd5; outport_enable = 1;
        LDM_value_in = 16'h5A5A; input_port_in = 16'hC3C3; tick();
        chk("lit_pop_md", 32'(mem_data_out), 32'h1234);
        chk("lit_pop_sp", 32'(sp_out), 32'hFFF);

        // store then load
        nop(); mem_write = 1; result_in = 16'h0040; read_data2_in = 16'hBEEF; tick();
        nop(); mem_read = 1; result_in = 16'h0040; reg_write = 1; reg_write_address = 3'd3; tick();
        chk("lit_load_md", 32'(mem_data_out), 32'hBEEF);
        chk("lit_load_rw", 32'(reg_write_out), 32'h1);

        // read-during-write returns old data
        nop(); mem_read = 1; mem_write = 1; result_in = 16'h0040; read_data2_in = 16'h1111; tick();
        chk("lit_rdw_old", 32'(mem_data_out), 32'hBEEF);
        load(16'h0040);
        chk("lit_rdw_new", 32'(mem_data_out), 32'h1111);

        // Rdest address / Rdest data, then read via select 11
        nop(); mem_write = 1; memory_address_select = 2'b01; read_data1_in = 16'hF050;
        memory_write_src_select = 2'b01; tick();
        nop(); mem_read = 1; memory_address_select = 2'b11; result_in = 16'h0050; tick();
        chk("lit_rdest_md", 32'(mem_data_out), 32'hF050);

        // CALL: 32-bit push of PC+1
        nop(); mem_push = 1; memory_address_select = 2'b10; memory_write_src_select = 2'b11;
        pc_plus_one_in = 32'h0001_0020; reg_write = 1; reg_write_address = 3'd7; #1;
        chk("lit_call_stall1", 32'(stall), 32'h1);
        tick();
        chk("lit_call_bubble", 32'(reg_write_out), 32'h0);
        chk("lit_call_sp1", 32'(sp_out), 32'hFFE);
        #1;
        chk("lit_call_stall2", 32'(stall), 32'h0);
        tick();
        chk("lit_call_sp2", 32'(sp_out), 32'hFFD);
        load(16'h0FFF);
        chk("lit_call_hi", 32'(mem_data_out), 32'h0001);
        load(16'h0FFE);
        chk("lit_call_lo", 32'(mem_data_out), 32'h0020);

        // RET: PC pop
        nop(); mem_pop = 1; pc_choose_memory = 1; memory_address_select = 2'b10; #1;
        chk("lit_ret_stall", 32'(stall), 32'h1);
        tick();
        chk("lit_ret_valid0", 32'(pc_from_mem_valid), 32'h0);
        tick();
        chk("lit_ret_valid1", 32'(pc_from_mem_valid), 32'h1);
        chk("lit_ret_pc", new_pc_out, 32'h0001_0020);
        chk("lit_ret_sp", 32'(sp_out), 32'hFFF);
        nop(); tick();
        chk("lit_ret_pulse", 32'(pc_from_mem_valid), 32'h0);

        // push and pop together resolve as push
        nop(); mem_push = 1; mem_pop = 1; memory_address_select = 2'b10; read_data2_in = 16'h7777; tick();
        chk("lit_pushpop_sp", 32'(sp_out), 32'hFFE);
        nop(); mem_pop = 1; mem_read = 1; tick();
        chk("lit_pushpop_md", 32'(mem_data_out), 32'h7777);

        // SP wrap on pop at 0xFFF, then push back across the boundary
        nop(); mem_pop = 1; memory_address_select = 2'b10; tick();
        chk("lit_wrap_sp", 32'(sp_out), 32'h000);
        nop(); mem_push = 1; memory_address_select = 2'b10; read_data2_in = 16'h4242; tick();
        chk("lit_wrap_back", 32'(sp_out), 32'hFFF);

        // reset during SECOND of a 32-bit push
        nop(); mem_push = 1; memory_address_select = 2'b10; memory_write_src_select = 2'b10;
        pc_in = 32'hAAAA_5555; tick();
        chk("lit_abort_sp1", 32'(sp_out), 32'hFFE);
        reset = 1; #1;
        chk("lit_abort_stall", 32'(stall), 32'h0);
        tick();
        chk("lit_abort_sp", 32'(sp_out), 32'hFFF);
        reset = 0; nop(); tick();
        load(16'h0FFF);
        chk("lit_abort_hi", 32'(mem_data_out), 32'hAAAA);
        load(16'h0FFE);
        chk("lit_abort_lo_kept", 32'(mem_data_out), 32'h0020);
        load(16'h0000);
        chk("lit_wrap_mem0", 32'(mem_data_out), 32'h4242);

        nop(); tick();
        @(negedge clk);
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the 16-bit RISC pipeline. Consumes the EX/MEM pipeline buffer produced by the execute stage and performs data-memory loads and stores, stack push and pop, and two-word PC save/restore for CALL/RET/INT/RTI. It owns the stack pointer and drives the MEM/WB pipeline buffer. It also drives the redirect PC and a stall back to earlier stages.

## Interface

Parameters:
- ADDR_W, 12, data-memory address width; depth is 2**ADDR_W 16-bit words.
- SP_RESET, 2**ADDR_W-1, stack-pointer value after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- result_in, read_data1_in, read_data2_in  in  16 each  ALU result, Rdest data and Rsrc data from EX/MEM.
- pc_in, pc_plus_one_in  in  32 each  PC and PC+1 from EX/MEM.
- LDM_value_in, input_port_in  in  16 each  pass-through values.
- mem_read, mem_write, mem_push, mem_pop  in  1 each  memory operation.
- memory_address_select  in  2  selects the address: 00 result_in; 01 read_data1_in; 10 stack; 11 result_in.
- memory_write_src_select  in  2  selects the write data: 00 read_data2_in; 01 read_data1_in; 10 pc_in (32-bit); 11 pc_plus_one_in (32-bit).
- pc_choose_memory  in  1  a pop restores a 32-bit PC.
- reg_write, outport_enable  in  1 each  pass-through controls.
- wb_sel  in  2  pass-through control.
- reg_write_address  in  3  pass-through control.
- mem_data_out, result_out, LDM_value_out, input_port_out  out  16 each  MEM/WB buffer.
- reg_write_out, outport_enable_out  out  1 each  MEM/WB buffer.
- wb_sel_out  out  2  MEM/WB buffer.
- reg_write_address_out  out  3  MEM/WB buffer.
- new_pc_out  out  32  restored PC.
- pc_from_mem_valid  out  1  one-cycle pulse; new_pc_out is valid.
- stall  out  1  combinational; EX/MEM and earlier stages must hold while high.
- sp_out  out  ADDR_W  current stack pointer (debug/verification).

## Operation

Word operations:
- A word operation is any operation except a 32-bit push or a PC pop.
- A 32-bit push is mem_push with memory_write_src_select = 1x.
- A PC pop is mem_pop with pc_choose_memory = 1.

Addressing and stack pointer:
- Non-stack address is the low ADDR_W bits of the selected 16-bit source.
- Push: write to mem[SP], then SP <= SP-1.
- Pop: SP <= SP+1; read mem[SP+1].
- SP arithmetic wraps modulo 2**ADDR_W. There is no overflow or underflow detection.

Memory access:
- mem_write stores 16-bit write data at the address.
- mem_read loads the address into mem_data_out.
- Push has priority over mem_write.
- Pop has priority over mem_read.
- push and pop together is illegal. It is resolved as push.
- Memory contents are not cleared by reset.

32-bit FSM (states IDLE, SECOND):
- 32-bit push:
  - IDLE: write src[31:16] at SP, SP-1, stall=1, go to SECOND.
  - SECOND: write src[15:0] at SP, SP-1, stall=0, go to IDLE.
  - The high word ends at the higher address.
- PC pop:
  - IDLE: SP+1, latch mem[SP+1] into a 16-bit hold register as the low word, stall=1, go to SECOND.
  - SECOND: SP+1, new_pc_out <= {mem[SP+1], hold}, pc_from_mem_valid <= 1, go to IDLE.
- Word operations complete in IDLE with stall=0.

MEM/WB buffer:
- The buffer loads on every non-stall cycle.
- On a stall cycle it loads a bubble: reg_write_out=0, outport_enable_out=0, other fields unchanged.

## Timing

- Data memory has asynchronous read and synchronous write.
- Read-during-write to the same address in the same cycle returns the old data.
- Load latency is 1: mem_data_out is valid the cycle after mem_read is sampled.
- A 32-bit push or PC pop takes 2 cycles. stall is high during the first cycle only.
- pc_from_mem_valid is high exactly 1 cycle, the cycle after SECOND completes.
- Reset, including during SECOND:
  - FSM goes to IDLE, SP <= SP_RESET, the hold register is cleared.
  - All registered outputs go to 0. stall goes to 0 in the same cycle.
  - The partial 32-bit operation is abandoned and its first-word write remains in memory.

## Structure

- Package mem_stage_pkg holds:
  - state enum {IDLE, SECOND};
  - address-select constants ADDR_RESULT, ADDR_RDEST, ADDR_STACK;
  - write-src constants SRC_RSRC, SRC_RDEST, SRC_PC, SRC_PC1.
- One sub-module, data_memory: parameter ADDR_W, 16-bit wide, async read, sync write, no reset.
- The SP, FSM, hold register and MEM/WB buffer live in memory_stage.

## Test plan

All scenarios use ADDR_W=12.
- Reset:
  - Stimulus: assert reset.
  - Required response: sp_out=0xFFF, all outputs 0, stall=0.
- Word push then pop:
  - Stimulus: push with read_data2_in=0x1234.
  - Required response: mem[0xFFF]=0x1234, SP=0xFFE.
  - Stimulus: pop with mem_read.
  - Required response: mem_data_out=0x1234 the next cycle, SP=0xFFF.
- Store then load:
  - Stimulus: mem_write with result_in=0x0040 and read_data2_in=0xBEEF, then mem_read at 0x0040.
  - Required response: mem_data_out=0xBEEF; reg_write_out follows reg_write.
- CALL push:
  - Stimulus: push with SRC_PC1 and pc_plus_one_in=0x0001_0020.
  - Required response: stall high for 1 cycle, mem[0xFFF]=0x0001, mem[0xFFE]=0x0020, SP=0xFFD, reg_write_out=0 during the stall cycle.
- RET:
  - Stimulus: PC pop from the CALL state above.
  - Required response: new_pc_out=0x0001_0020, pc_from_mem_valid pulses once, SP=0xFFF.
- Wrap and reset:
  - Stimulus: pop at SP=0xFFF.
  - Required response: SP=0x000.
  - Stimulus: assert reset during SECOND of a 32-bit push.
  - Required response: SP=0xFFF, FSM IDLE, stall=0, only the high word is written.
